// File: rtl/seq_bin2bcd_pkg.sv
// rtl/seq_bin2bcd_pkg.sv - shared state encoding and BCD adjust constants for seq_bin2bcd
package seq_bin2bcd_pkg;

  localparam logic ST_IDLE  = 1'b0;
  localparam logic ST_SHIFT = 1'b1;

  typedef enum logic {
    IDLE  = ST_IDLE,
    SHIFT = ST_SHIFT
  } state_t;

  localparam int         BCD_DIGIT_W = 4;
  localparam logic [3:0] ADJ_THRESH  = 4'd5;
  localparam logic [3:0] ADJ_ADD     = 4'd3;

endpackage

// File: rtl/bcd_digit_adj.sv
// rtl/bcd_digit_adj.sv - one BCD digit's add-3-if-at-least-5 correction cell
import seq_bin2bcd_pkg::*;

module bcd_digit_adj (
  input  logic [3:0] d,
  output logic [3:0] q
);

  // Wraps in 4 bits; only the top digit can wrap and its carry is the overflow bit.
  assign q = (d >= ADJ_THRESH) ? d + ADJ_ADD : d;

endmodule

// File: rtl/seq_bin2bcd.sv
// rtl/seq_bin2bcd.sv - iterative double-dabble converter; SEQ_BIN2BCD_BLANK_EN adds leading-zero blank output
import seq_bin2bcd_pkg::*;

module seq_bin2bcd #(
  parameter int BIN_W  = 8,
  parameter int DIGITS = 3
) (
  input  logic                          clk,
  input  logic                          resetn,
  input  logic                          start,
  input  logic [BIN_W-1:0]              bin_in,
  output logic                          busy,
  output logic                          done,
  output logic [BCD_DIGIT_W*DIGITS-1:0] bcd_out,
`ifdef SEQ_BIN2BCD_BLANK_EN
  output logic [DIGITS-1:0]             blank,
`endif
  output logic                          overflow
);

  localparam int BCD_W = BCD_DIGIT_W * DIGITS;
  localparam int CNT_W = $clog2(BIN_W + 1);

  generate
    if (BIN_W < 1 || DIGITS < 1) begin : g_bad_params
      $error("seq_bin2bcd: BIN_W and DIGITS must both be >= 1");
    end
  endgenerate

  state_t             state, state_nxt;
  logic [CNT_W-1:0]   cnt;
  logic [BIN_W-1:0]   bin_sr;
  logic [BCD_W-1:0]   scratch;
  logic [BCD_W-1:0]   adj;
  logic [BCD_W-1:0]   shifted;
  logic               ovf_sc;
  logic               ovf_nxt;
  logic               last;

  for (genvar i = 0; i < DIGITS; i++) begin : g_adj
    bcd_digit_adj u_adj (
      .d (scratch[i*BCD_DIGIT_W +: BCD_DIGIT_W]),
      .q (adj[i*BCD_DIGIT_W +: BCD_DIGIT_W])
    );
  end

  // Top bit of the adjusted scratch is what falls off the left end on this shift.
  assign shifted = {adj[BCD_W-2:0], bin_sr[BIN_W-1]};
  assign ovf_nxt = ovf_sc | adj[BCD_W-1];
  assign last    = (cnt == CNT_W'(1));

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) state <= IDLE;
    else         state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    busy      = 1'b0;
    case (state)
      IDLE: begin
        if (start) state_nxt = SHIFT;
      end
      SHIFT: begin
        busy = 1'b1;
        if (last) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

`ifdef SEQ_BIN2BCD_BLANK_EN
  logic [DIGITS-1:0] blank_nxt;
  logic              hz;

  always_comb begin
    blank_nxt = '0;
    hz        = 1'b1;
    for (int i = DIGITS - 1; i >= 1; i--) begin
      hz           = hz & (shifted[i*BCD_DIGIT_W +: BCD_DIGIT_W] == 4'd0);
      blank_nxt[i] = hz;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn)                      blank <= '0;
    else if (state == SHIFT && last)  blank <= blank_nxt;
  end
`endif

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      cnt      <= '0;
      bin_sr   <= '0;
      scratch  <= '0;
      ovf_sc   <= 1'b0;
      bcd_out  <= '0;
      overflow <= 1'b0;
      done     <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            bin_sr  <= bin_in;
            scratch <= '0;
            ovf_sc  <= 1'b0;
            cnt     <= CNT_W'(BIN_W);
          end
        end
        SHIFT: begin
          scratch <= shifted;
          bin_sr  <= bin_sr << 1;
          ovf_sc  <= ovf_nxt;
          cnt     <= cnt - CNT_W'(1);
          if (last) begin
            bcd_out  <= shifted;
            overflow <= ovf_nxt;
            done     <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_seq_bin2bcd.sv
// tb/tb_seq_bin2bcd.sv - scoreboard bench for seq_bin2bcd at 3 and 2 digits; checks blank when SEQ_BIN2BCD_BLANK_EN is defined
module tb_seq_bin2bcd;

  localparam int BIN_W = 8;

  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic        start = 1'b0;
  logic [7:0]  bin_in = 8'd0;

  logic        busy3, done3, ovf3;
  logic [11:0] bcd3;
  logic        busy2, done2, ovf2;
  logic [7:0]  bcd2;
`ifdef SEQ_BIN2BCD_BLANK_EN
  logic [2:0]  blank3;
  logic [1:0]  blank2;
`endif

  seq_bin2bcd #(.BIN_W(BIN_W), .DIGITS(3)) dut (
    .clk(clk), .resetn(resetn), .start(start), .bin_in(bin_in),
    .busy(busy3), .done(done3), .bcd_out(bcd3),
`ifdef SEQ_BIN2BCD_BLANK_EN
    .blank(blank3),
`endif
    .overflow(ovf3)
  );

  seq_bin2bcd #(.BIN_W(BIN_W), .DIGITS(2)) dut2 (
    .clk(clk), .resetn(resetn), .start(start), .bin_in(bin_in),
    .busy(busy2), .done(done2), .bcd_out(bcd2),
`ifdef SEQ_BIN2BCD_BLANK_EN
    .blank(blank2),
`endif
    .overflow(ovf2)
  );

  always #5 clk = ~clk;

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int unsigned v;
    int unsigned ecyc;
  } exp_t;

  exp_t        q[$];
  int unsigned last_exp = 0;
  int          checks = 0;
  int          errors = 0;

  int unsigned l_bcd3 = 0, l_ovf3 = 0, l_blk3 = 0;
  int unsigned l_bcd2 = 0, l_ovf2 = 0, l_blk2 = 0;

  function automatic int unsigned pow10(int n);
    int unsigned r = 1;
    for (int i = 0; i < n; i++) r = r * 10;
    return r;
  endfunction

  function automatic int unsigned bcd_of(int unsigned v, int nd);
    int unsigned r = 0;
    for (int i = 0; i < nd; i++) begin
      r = r | ((v % 10) << (4 * i));
      v = v / 10;
    end
    return r;
  endfunction

  function automatic int unsigned blank_of(int unsigned v, int nd);
    int unsigned t = v % pow10(nd);
    int unsigned r = 0;
    for (int i = 1; i < nd; i++)
      if (t / pow10(i) == 0) r = r | (1 << i);
    return r;
  endfunction

  task automatic chk(string name, int unsigned act, int unsigned exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h at cycle %0d", name, act, exp, cyc);
    end
  endtask

  // Monitor: expected outputs come only from the scoreboard queue and the model.
  always @(negedge clk) begin
    if (resetn) begin
      bit d_exp, b_exp;
      d_exp = (q.size() > 0) && (cyc == q[0].ecyc);
      b_exp = (q.size() > 0) && (cyc < q[0].ecyc);
      if (d_exp) begin
        exp_t e;
        e = q.pop_front();
        l_bcd3 = bcd_of(e.v, 3);
        l_ovf3 = (e.v >= pow10(3)) ? 1 : 0;
        l_blk3 = blank_of(e.v, 3);
        l_bcd2 = bcd_of(e.v, 2);
        l_ovf2 = (e.v >= pow10(2)) ? 1 : 0;
        l_blk2 = blank_of(e.v, 2);
      end
      chk("done3", done3, d_exp);
      chk("busy3", busy3, b_exp);
      chk("done2", done2, d_exp);
      chk("busy2", busy2, b_exp);
      chk("bcd3", bcd3, l_bcd3);
      chk("ovf3", ovf3, l_ovf3);
      chk("bcd2", bcd2, l_bcd2);
      chk("ovf2", ovf2, l_ovf2);
`ifdef SEQ_BIN2BCD_BLANK_EN
      chk("blank3", blank3, l_blk3);
      chk("blank2", blank2, l_blk2);
`endif
    end
  end

  // Waits until the model says the DUT is idle, then issues one accepted start.
  task automatic issue(int unsigned v, bit hold);
    @(negedge clk);
    while (cyc < last_exp) @(negedge clk);
    start  = 1'b1;
    bin_in = v[7:0];
    @(posedge clk);
    #1;
    q.push_back('{v: v, ecyc: cyc + BIN_W});
    last_exp = cyc + BIN_W;
    @(negedge clk);
    if (!hold) start = 1'b0;
    bin_in = 8'($urandom);
  endtask

  task automatic chk_reset_outputs(string tag);
    chk({tag, "_busy3"}, busy3, 0);
    chk({tag, "_done3"}, done3, 0);
    chk({tag, "_bcd3"},  bcd3, 0);
    chk({tag, "_ovf3"},  ovf3, 0);
    chk({tag, "_busy2"}, busy2, 0);
    chk({tag, "_bcd2"},  bcd2, 0);
    chk({tag, "_ovf2"},  ovf2, 0);
`ifdef SEQ_BIN2BCD_BLANK_EN
    chk({tag, "_blank3"}, blank3, 0);
`endif
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) @(posedge clk);
    #1;
    chk_reset_outputs("reset");
    @(negedge clk);
    resetn = 1'b1;

    issue(255, 0);
    issue(0, 0);
    issue(99, 0);
    issue(7, 0);

    // Start re-asserted with another value while busy must be ignored.
    issue(42, 0);
    start = 1'b1; bin_in = 8'd7;
    repeat (2) @(negedge clk);
    start = 1'b0;

    // Held start: 200 then 13 offered on the done cycle, back to back.
    issue(200, 1);
    issue(13, 0);

    issue(100, 0);
    issue(45, 0);

    // Asynchronous reset during the fourth cycle of a conversion.
    issue(123, 0);
    repeat (3) @(posedge clk);
    #3;
    resetn = 1'b0;
    #1;
    chk_reset_outputs("midreset");
    q.delete();
    last_exp = cyc;
    l_bcd3 = 0; l_ovf3 = 0; l_blk3 = 0;
    l_bcd2 = 0; l_ovf2 = 0; l_blk2 = 0;
    @(posedge clk);
    #3;
    resetn = 1'b1;

    issue(187, 0);

    for (int i = 0; i < 40; i++) begin
      int unsigned v;
      bit          h;
      v = $urandom_range(0, 255);
      h = ($urandom_range(0, 3) == 0);
      issue(v, h);
      if (!h) repeat ($urandom_range(0, 3)) @(negedge clk);
    end
    start = 1'b0;

    while (cyc < last_exp + 3) @(negedge clk);
    chk("queue_empty", q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
